if_fetch: RTL



---
 rtl/if_fetch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch -- instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Builds each 32-bit instruction from four byte reads on the shared,
// arbitrated memory port and presents it (with its pc) to the IF_ID register.
//
// Optional build macro: ICACHE_EN
//   Undefined (default): every instruction is fetched byte by byte from memory.
//   Defined: a direct-mapped, one-word-per-line I-cache of ICACHE_LINES entries
//            sits in front of the byte fetch; a hit skips the memory port.
//
// Parameters:
//   ICACHE_LINES  number of cache lines (power of two, >= 2; ICACHE_EN only)
//   RESET_PC      first fetch address after reset
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall_i         downstream stall; holds the presented instruction
//   redirect_i      taken branch/jump from EX; flush and refetch
//   redirect_pc_i   new fetch address (used as given, alignment is EX's job)
//   mem_req_o       byte read request to the arbiter
//   mem_addr_o      byte address of the request
//   mem_gnt_i       arbiter accepted the request this cycle
//   mem_data_i      read byte, valid exactly one cycle after an accept
//   inst_valid_o    pc_o/inst_o hold a complete instruction
//   pc_o            address of inst_o
//   inst_o          fetched instruction, little-endian byte assembly
//   dbg_state       current FSM state (ISSUE=0, DRAIN=1, HOLD=2)
//
// Handshakes:
//   Memory side: a byte request transfers in the cycle where
//   mem_req_o & mem_gnt_i; while not granted, mem_req_o stays high and
//   mem_addr_o stays put. Pipeline side: inst_valid_o is "valid" and
//   !stall_i is "ready"; the instruction transfers in a cycle where both
//   hold, and pc_o/inst_o are stable while inst_valid_o & stall_i.
// ============================================================================
module if_fetch #(
  parameter int          ICACHE_LINES = 128,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_ISSUE = 2'd0;  // issuing the four byte requests
  localparam logic [1:0] ST_DRAIN = 2'd1;  // all issued, waiting for last byte
  localparam logic [1:0] ST_HOLD  = 2'd2;  // instruction presented downstream

  // Cache indexing needs at least one index bit and a power-of-two size.
  generate
    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
      $error("if_fetch: ICACHE_LINES must be a power of two >= 2");
    end
  endgenerate

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [1:0]  issue_cnt;
  logic [1:0]  recv_cnt;
  logic        byte_pend;   // a request was accepted last cycle
  logic        drop_q;      // that request was accepted in a redirect cycle
  logic [23:0] asm_q;       // byte lanes 0..2 of the word being assembled

  logic        accept;
  logic        byte_vld;
  logic        last_byte;
  logic        cache_hit;
  logic [31:0] cache_rdata;

  assign accept    = mem_req_o & mem_gnt_i;
  assign byte_vld  = byte_pend & ~drop_q;
  // The fourth byte can only land after the fourth accept, i.e. in DRAIN.
  assign last_byte = byte_vld && (state == ST_DRAIN) && (recv_cnt == 2'd3);
  assign dbg_state = state;

  // Request generation. Gated by rst so the port is quiet during reset even
  // though the FSM already sits in ISSUE.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = 32'h0;
    if (!rst) begin
      mem_addr_o = fetch_pc + {30'h0, issue_cnt};
      mem_req_o  = (state == ST_ISSUE) && !cache_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ISSUE;
      fetch_pc     <= RESET_PC;
      issue_cnt    <= 2'd0;
      recv_cnt     <= 2'd0;
      byte_pend    <= 1'b0;
      drop_q       <= 1'b0;
      asm_q        <= 24'h0;
      inst_valid_o <= 1'b0;
      pc_o         <= RESET_PC;
      inst_o       <= 32'h0;
    end else begin
      byte_pend <= accept;
      // A byte requested in the redirect cycle belongs to the old stream.
      drop_q    <= redirect_i;

      if (redirect_i) begin
        fetch_pc     <= redirect_pc_i;
        state        <= ST_ISSUE;
        issue_cnt    <= 2'd0;
        recv_cnt     <= 2'd0;
        inst_valid_o <= 1'b0;
      end else begin
        // Lanes 0..2 are buffered; lane 3 goes straight into inst_o.
        if (byte_vld && state != ST_HOLD) begin
          recv_cnt <= recv_cnt + 2'd1;
          case (recv_cnt)
            2'd0:    asm_q[7:0]   <= mem_data_i;
            2'd1:    asm_q[15:8]  <= mem_data_i;
            2'd2:    asm_q[23:16] <= mem_data_i;
            default: ;
          endcase
        end

        case (state)
          ST_ISSUE: begin
            if (cache_hit) begin
              inst_o       <= cache_rdata;
              pc_o         <= fetch_pc;
              inst_valid_o <= 1'b1;
              state        <= ST_HOLD;
            end else if (accept) begin
              issue_cnt <= issue_cnt + 2'd1;
              if (issue_cnt == 2'd3) begin
                state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (last_byte) begin
              inst_o       <= {mem_data_i, asm_q};
              pc_o         <= fetch_pc;
              inst_valid_o <= 1'b1;
              state        <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!stall_i) begin
              inst_valid_o <= 1'b0;
              fetch_pc     <= fetch_pc + 32'd4;
              state        <= ST_ISSUE;
            end
          end
          default: begin
            state <= ST_ISSUE;
          end
        endcase
      end
    end
  end

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] line_vld;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    fill_we;

  assign idx = fetch_pc[IDX_W+1:2];
  assign tag = fetch_pc[31:IDX_W+2];

  // Lookup only on ISSUE entry (nothing issued yet for this fetch).
  assign cache_hit   = (state == ST_ISSUE) && (issue_cnt == 2'd0) &&
                       line_vld[idx] && (tag_mem[idx] == tag);
  assign cache_rdata = data_mem[idx];

  // Fill on completion of a miss; a redirect in that cycle aborts the fill.
  assign fill_we = !rst && !redirect_i && last_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld <= '0;
    end else if (fill_we) begin
      line_vld[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= {mem_data_i, asm_q};
    end
  end
`else
  assign cache_hit   = 1'b0;
  assign cache_rdata = 32'h0;
`endif

endmodule
